store_outstanding_limiter: RTL and testbench

//  Sits between the LSU store path and the write-back D$/AXI store port. Classifies each

---
 rtl/store_outstanding_limiter.sv | 108 ++++++++++
 tb/tb_store_outstanding_limiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_outstanding_limiter.sv
// Store outstanding limiter: classifies stores as cached/uncached, caps in-flight
// stores per class and provides a fence drain that blocks new stores until all are acked.
module store_outstanding_limiter #(
  parameter int unsigned       ADDR_W       = 64,
  parameter logic [ADDR_W-1:0] CACHED_BASE  = ADDR_W'(64'h8000_0000),
  parameter logic [ADDR_W-1:0] CACHED_LEN   = ADDR_W'(64'h4000_0000),
  parameter int unsigned       MAX_UNCACHED = 7,
  parameter int unsigned       MAX_CACHED   = 0,
  parameter int unsigned       CNT_W        = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic              req_uncached_o,
  input  logic              rsp_valid_i,
  input  logic              rsp_uncached_i,
  input  logic              fence_i,
  output logic              fence_done_o,
  output logic              busy_o,
  output logic              underflow_o
);

  localparam int unsigned SUM_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LIM_U = CNT_W'(MAX_UNCACHED);
  localparam logic [CNT_W-1:0] LIM_C = (MAX_CACHED == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_CACHED);
  // Region end held one bit wider so BASE+LEN never wraps.
  localparam logic [SUM_W-1:0] REGION_END = SUM_W'(CACHED_BASE) + SUM_W'(CACHED_LEN);

  typedef enum logic [0:0] {S_IDLE, S_DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_c, cnt_u, cnt_c_nxt, cnt_u_nxt;
  logic [CNT_W-1:0] cls_cnt, cls_lim;
  logic             allow, issue, drain_done, underflow_nxt;
  logic             inc_c, inc_u, dec_c, dec_u;

  assign req_uncached_o = !((CACHED_LEN != '0) && (req_addr_i >= CACHED_BASE) &&
                            (SUM_W'(req_addr_i) < REGION_END));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      fence_done_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      fence_done_o <= drain_done;
    end
  end

  // Next-state: drain completes on the edge where both counts become zero
  always_comb begin
    state_nxt  = state;
    drain_done = 1'b0;
    case (state)
      S_IDLE:  if (fence_i) state_nxt = S_DRAIN;
      S_DRAIN: if ((cnt_c_nxt == '0) && (cnt_u_nxt == '0)) begin
        state_nxt  = S_IDLE;
        drain_done = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output gating uses registered counts only, so rsp_* never reaches ready/valid
  always_comb begin
    cls_cnt     = req_uncached_o ? cnt_u : cnt_c;
    cls_lim     = req_uncached_o ? LIM_U : LIM_C;
    allow       = !rst_i && (state == S_IDLE) && (cls_cnt < cls_lim);
    req_valid_o = req_valid_i & allow;
    req_ready_o = req_ready_i & allow;
  end

  // Counter update; a response to an empty class is dropped and flagged
  always_comb begin
    issue         = req_valid_i & req_ready_o;
    inc_u         = issue & req_uncached_o;
    inc_c         = issue & !req_uncached_o;
    dec_u         = rsp_valid_i & rsp_uncached_i;
    dec_c         = rsp_valid_i & !rsp_uncached_i;
    cnt_u_nxt     = cnt_u;
    cnt_c_nxt     = cnt_c;
    underflow_nxt = underflow_o | (dec_u & (cnt_u == '0)) | (dec_c & (cnt_c == '0));
    if (inc_u && !dec_u)                        cnt_u_nxt = cnt_u + CNT_W'(1);
    else if (!inc_u && dec_u && (cnt_u != '0))  cnt_u_nxt = cnt_u - CNT_W'(1);
    if (inc_c && !dec_c)                        cnt_c_nxt = cnt_c + CNT_W'(1);
    else if (!inc_c && dec_c && (cnt_c != '0))  cnt_c_nxt = cnt_c - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_c       <= '0;
      cnt_u       <= '0;
      busy_o      <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      cnt_c       <= cnt_c_nxt;
      cnt_u       <= cnt_u_nxt;
      busy_o      <= (cnt_c_nxt != '0) || (cnt_u_nxt != '0);
      underflow_o <= underflow_nxt;
    end
  end

endmodule

// File: tb/tb_store_outstanding_limiter.sv
// Directed testbench for store_outstanding_limiter: a vector table for classification
// and basic counting, plus hand-written sequences for limits, fences and underflow.
module tb_store_outstanding_limiter;

  localparam logic [63:0] A_C = 64'h0000_0000_8000_1000;
  localparam logic [63:0] A_U = 64'h0000_0000_1000_0000;
  localparam logic [63:0] A_E = 64'h0000_0000_C000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0, req_ready_i = 1'b0;
  logic [63:0] req_addr_i = '0;
  logic        req_valid_o, req_ready_o, req_uncached_o;
  logic        rsp_valid_i = 1'b0, rsp_uncached_i = 1'b0, fence_i = 1'b0;
  logic        fence_done_o, busy_o, underflow_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  store_outstanding_limiter dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_uncached_o(req_uncached_o),
    .rsp_valid_i(rsp_valid_i), .rsp_uncached_i(rsp_uncached_i), .fence_i(fence_i),
    .fence_done_o(fence_done_o), .busy_o(busy_o), .underflow_o(underflow_o)
  );

  typedef struct {
    logic        vi, ri;
    logic [63:0] addr;
    logic        rv, ru, fe;
    logic        e_rdy, e_vld, e_unc, e_busy;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic vi, input logic ri, input logic [63:0] addr,
                      input logic rv, input logic ru, input logic fe);
    req_valid_i    = vi;
    req_ready_i    = ri;
    req_addr_i     = addr;
    rsp_valid_i    = rv;
    rsp_uncached_i = ru;
    fence_i        = fe;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1, 1, A_C, 0, 0, 0);
    check("rst_ready_gate", req_ready_o, 1'b0);
    check("rst_valid_gate", req_valid_o, 1'b0);
    step(0, 0, A_C, 0, 0, 0);
    tick();
    tick();
    check("rst_busy", busy_o, 1'b0);
    check("rst_underflow", underflow_o, 1'b0);
    check("rst_fence_done", fence_done_o, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    //            vi  ri  addr                    rv  ru  fe  rdy vld unc busy
    vecs[0] = '{1'b0, 1'b1, A_C,                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, A_C,                  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, A_U,                  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, A_E,                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 64'h8000_0000,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 64'hBFFF_FFFF,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 64'h7FFF_FFFF,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    do_reset();

    // Classification and basic counting
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].vi, vecs[i].ri, vecs[i].addr, vecs[i].rv, vecs[i].ru, vecs[i].fe);
      check($sformatf("vec%0d_ready", i), req_ready_o, vecs[i].e_rdy);
      check($sformatf("vec%0d_valid", i), req_valid_o, vecs[i].e_vld);
      check($sformatf("vec%0d_uncached", i), req_uncached_o, vecs[i].e_unc);
      tick();
      check($sformatf("vec%0d_busy", i), busy_o, vecs[i].e_busy);
      check($sformatf("vec%0d_underflow", i), underflow_o, 1'b0);
    end

    // Per-class limits
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1, 1, A_U, 0, 0, 0);
      check($sformatf("unc_fill%0d", i), req_ready_o, 1'b1);
      tick();
    end
    step(1, 1, A_U, 0, 0, 0);
    check("unc_limit_ready", req_ready_o, 1'b0);
    check("unc_limit_valid", req_valid_o, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(1, 1, A_C, 0, 0, 0);
      check($sformatf("cac_fill%0d", i), req_ready_o, 1'b1);
      tick();
    end
    step(1, 1, A_C, 0, 0, 0);
    check("cac_limit_ready", req_ready_o, 1'b0);
    step(0, 1, A_U, 1, 1, 0);
    check("unc_rsp_same_cycle", req_ready_o, 1'b0);
    tick();
    step(0, 1, A_C, 0, 0, 0);
    check("cac_still_full", req_ready_o, 1'b0);
    step(0, 1, A_U, 0, 0, 0);
    check("unc_freed", req_ready_o, 1'b1);

    // Same-cycle issue and response
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, A_U, 0, 0, 0);
      tick();
    end
    step(1, 1, A_U, 1, 1, 0);
    check("same_cls_issue", req_ready_o, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, A_U, 0, 0, 0);
      check($sformatf("refill%0d", i), req_ready_o, 1'b1);
      tick();
    end
    step(1, 1, A_U, 0, 0, 0);
    check("refill_limit", req_ready_o, 1'b0);
    step(1, 1, A_C, 1, 1, 0);
    check("mixed_issue", req_ready_o, 1'b1);
    tick();
    step(0, 1, A_U, 0, 0, 0);
    check("mixed_unc_freed", req_ready_o, 1'b1);
    step(1, 1, A_U, 0, 0, 0);
    tick();
    step(1, 1, A_U, 0, 0, 0);
    check("mixed_unc_full", req_ready_o, 1'b0);
    step(0, 0, A_C, 1, 0, 0);
    tick();
    check("mixed_cac_ack", underflow_o, 1'b0);
    step(0, 0, A_C, 1, 0, 0);
    tick();
    check("cac_underflow", underflow_o, 1'b1);

    // Fence drain with stores in flight, repeated fence ignored
    do_reset();
    step(1, 1, A_C, 0, 0, 0);
    tick();
    step(1, 1, A_U, 0, 0, 1);
    check("fence_same_cycle_issue", req_ready_o, 1'b1);
    tick();
    check("drain_busy", busy_o, 1'b1);
    step(1, 1, A_C, 1, 0, 1);
    check("drain_block_ready", req_ready_o, 1'b0);
    check("drain_block_valid", req_valid_o, 1'b0);
    tick();
    check("drain_partial", fence_done_o, 1'b0);
    step(1, 1, A_U, 1, 1, 0);
    check("drain_block2", req_ready_o, 1'b0);
    tick();
    check("drain_done", fence_done_o, 1'b1);
    check("drain_idle_busy", busy_o, 1'b0);
    step(1, 1, A_C, 0, 0, 0);
    check("resume", req_ready_o, 1'b1);
    tick();
    check("pulse_single", fence_done_o, 1'b0);
    step(0, 0, A_C, 1, 0, 0);
    tick();

    // Fence with nothing in flight
    step(0, 0, A_C, 0, 0, 1);
    tick();
    check("fence0_edge1", fence_done_o, 1'b0);
    step(1, 1, A_C, 0, 0, 0);
    check("fence0_blocked", req_ready_o, 1'b0);
    tick();
    check("fence0_edge2", fence_done_o, 1'b1);
    step(0, 1, A_C, 0, 0, 0);
    check("fence0_resume", req_ready_o, 1'b1);
    tick();
    check("fence0_pulse_end", fence_done_o, 1'b0);

    // Underflow, then reset in the middle of a drain
    do_reset();
    step(0, 0, A_U, 1, 1, 0);
    tick();
    check("uf_set", underflow_o, 1'b1);
    check("uf_cnt_stays0", busy_o, 1'b0);
    step(0, 0, A_U, 0, 0, 0);
    tick();
    check("uf_sticky", underflow_o, 1'b1);
    step(1, 1, A_U, 0, 0, 0);
    tick();
    step(0, 0, A_U, 0, 0, 1);
    tick();
    step(0, 1, A_U, 0, 0, 0);
    check("in_drain_blocked", req_ready_o, 1'b0);
    do_reset();
    step(0, 1, A_U, 0, 0, 0);
    check("idle_after_rst", req_ready_o, 1'b1);
    tick();
    check("no_pulse_after_rst1", fence_done_o, 1'b0);
    step(0, 0, A_U, 0, 0, 0);
    tick();
    check("no_pulse_after_rst2", fence_done_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
